// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side handshake bundle for the shared UART TX arbiter.
// The slave modport is the arbiter; the master side plays requesters and UART.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   reqtxen;
  logic [8*NREQ-1:0] reqdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   reqbusy;
  logic              uarttxen;
  logic [7:0]        uartdata;
  logic              uartbusy;

  modport master (
    output req,
    output reqtxen,
    output reqdata,
    output uartbusy,
    input  gnt,
    input  reqbusy,
    input  uarttxen,
    input  uartdata
  );

  modport slave (
    input  req,
    input  reqtxen,
    input  reqdata,
    input  uartbusy,
    output gnt,
    output reqbusy,
    output uarttxen,
    output uartdata
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic sharing of one UART transmitter between NREQ
// byte-stream requesters; a grant ends on EOP, request drop or idle timeout.
module uart_tx_arbiter #(
  parameter int          NREQ    = 2,
  parameter logic [7:0]  EOP     = 8'h0A,
  parameter int          TIMEOUT = 1024,
  parameter int          TW      = 10
) (
  input logic            clk,
  input logic            n_rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    SEND,
    HOLD,
    RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              eop_seen_q, eop_seen_d;
  logic              uarttxen_q, uarttxen_d;
  logic [7:0]        uartdata_q, uartdata_d;

  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     cand;
  logic [7:0]        owner_byte;
  logic              do_release;

  // Scan downward in offset so the nearest set request at/after rr_q wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = rr_q;
    cand       = rr_q;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = IW'((int'(rr_q) + off) % NREQ);
      if (bus.req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_byte = bus.reqdata[{owner_q, 3'b000} +: 8];

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    tmo_d      = tmo_q;
    eop_seen_d = eop_seen_q;
    uarttxen_d = 1'b0;
    uartdata_d = uartdata_q;
    do_release = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          owner_d         = pick_idx;
          tmo_d           = '0;
          state_d         = GRANT;
        end
      end

      // A byte strobe outranks a simultaneous request drop.
      GRANT: begin
        if (bus.reqtxen[owner_q] && !bus.uartbusy) begin
          uarttxen_d = 1'b1;
          uartdata_d = owner_byte;
          eop_seen_d = (owner_byte == EOP);
          tmo_d      = '0;
          state_d    = SEND;
        end else if (!bus.req[owner_q]) begin
          do_release = 1'b1;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          do_release = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      SEND: begin
        state_d = HOLD;
      end

      HOLD: begin
        if (!bus.uartbusy) begin
          if (eop_seen_q) begin
            do_release = 1'b1;
          end else begin
            state_d = GRANT;
          end
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_release) begin
      gnt_d      = '0;
      rr_d       = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
      tmo_d      = '0;
      eop_seen_d = 1'b0;
      state_d    = RELEASE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_q       <= '0;
      owner_q    <= '0;
      tmo_q      <= '0;
      eop_seen_q <= 1'b0;
      uarttxen_q <= 1'b0;
      uartdata_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      tmo_q      <= tmo_d;
      eop_seen_q <= eop_seen_d;
      uarttxen_q <= uarttxen_d;
      uartdata_q <= uartdata_d;
    end
  end

  // Only the owner can ever see busy low, and only while parked in GRANT.
  always_comb begin
    bus.reqbusy = '1;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        bus.reqbusy[i] = (state_q != GRANT) || bus.uartbusy;
      end
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.uarttxen = uarttxen_q;
  assign bus.uartdata = uartdata_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requesters and a simple UART model
// drive the interface; every byte reaching the UART is popped and compared.
module tb_uart_tx_arbiter;

   localparam int NREQ     = 2;
   localparam int UARTBUSY = 6;

   logic clk;
   logic n_rst;

   uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

   uart_tx_arbiter #(
      .NREQ(NREQ),
      .EOP(8'h0A),
      .TIMEOUT(1024),
      .TW(10)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .bus(bus)
   );

   int checks = 0;
   int failures = 0;
   logic [7:0] expQ[$];
   logic prevTxen = 1'b0;
   logic uartBusyModel = 1'b0;
   int uartCount = 0;

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // UART model: busy asserts the cycle after the strobe and holds for UARTBUSY cycles
   always @(posedge clk) begin
      if (bus.uarttxen) begin
         uartBusyModel <= 1'b1;
         uartCount <= UARTBUSY;
      end else if (uartCount != 0) begin
         uartCount <= uartCount - 1;
         if (uartCount == 1) uartBusyModel <= 1'b0;
      end
   end

   assign bus.uartbusy = uartBusyModel;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
      end
   endtask

   // Monitor: each UART strobe must be one cycle wide and match the scoreboard head
   always @(negedge clk) begin
      if (bus.uarttxen) begin
         checkOutput("txen_pulse", {31'd0, prevTxen}, 32'd0);
         checkOutput("gnt_onehot", {31'd0, $onehot(bus.gnt)}, 32'd1);
         checkOutput("busy_in_send", {30'd0, bus.reqbusy}, 32'd3);
         checkOutput("sb_pending", {31'd0, (expQ.size() > 0)}, 32'd1);
         if (expQ.size() > 0) begin
            checkOutput("uart_byte", {24'd0, bus.uartdata}, {24'd0, expQ.pop_front()});
         end
      end
      prevTxen = bus.uarttxen;
   end

   // Requester idx offers one byte once its busy view drops, and records it as expected
   task automatic applyStimulus(input int idx, input logic [7:0] b);
      int n;
      n = 0;
      while (bus.reqbusy[idx] && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("busy_release", {31'd0, ~bus.reqbusy[idx]}, 32'd1);
      if (!bus.reqbusy[idx]) begin
         bus.reqdata[idx*8 +: 8] = b;
         bus.reqtxen[idx] = 1'b1;
         expQ.push_back(b);
         @(posedge clk); #1;
         bus.reqtxen[idx] = 1'b0;
      end
   endtask

   // Bounded wait for gnt to equal (or differ from) a value; n returns edges waited
   task automatic waitGnt(input string tag, input logic [1:0] want, input bit equal,
                          input int budget, output int n);
      bit ok;
      n = 0;
      ok = equal ? (bus.gnt === want) : (bus.gnt !== want);
      while (!ok && n < budget) begin
         @(posedge clk); #1;
         n++;
         ok = equal ? (bus.gnt === want) : (bus.gnt !== want);
      end
      checkOutput({tag, "_bound"}, {31'd0, ok}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      n_rst = 1'b0;
      bus.req = '0;
      bus.reqtxen = '0;
      bus.reqdata = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_gnt", {30'd0, bus.gnt}, 32'd0);
      checkOutput("rst_txen", {31'd0, bus.uarttxen}, 32'd0);
      checkOutput("rst_data", {24'd0, bus.uartdata}, 32'd0);
      checkOutput("rst_busy", {30'd0, bus.reqbusy}, 32'd3);
      n_rst = 1'b1;

      // Single requester sends "AB\n"
      $display("[TB] single requester");
      bus.req = 2'b01;
      @(posedge clk); #1;
      checkOutput("single_gnt", {30'd0, bus.gnt}, 32'd1);
      applyStimulus(0, 8'h41);
      applyStimulus(0, 8'h42);
      applyStimulus(0, 8'h0A);
      bus.req = 2'b00;
      waitGnt("single_drop", 2'b00, 1'b1, 100, n);
      repeat (3) @(posedge clk);
      #1;
      // rr pointer now 1: with both requesting, requester 1 wins
      bus.req = 2'b11;
      waitGnt("rr_grant", 2'b00, 1'b0, 10, n);
      checkOutput("rr_after_single", {30'd0, bus.gnt}, 32'd2);
      bus.req = 2'b00;
      waitGnt("rr_drop", 2'b00, 1'b1, 10, n);

      // Contention from reset, with a non-owner strobe thrown in
      $display("[TB] contention");
      n_rst = 1'b0;
      @(posedge clk); #1;
      n_rst = 1'b1;
      bus.req = 2'b11;
      @(posedge clk); #1;
      checkOutput("cont_first", {30'd0, bus.gnt}, 32'd1);
      bus.reqdata[15:8] = 8'h55;
      bus.reqtxen[1] = 1'b1;
      checkOutput("nonowner_busy", {31'd0, bus.reqbusy[1]}, 32'd1);
      @(posedge clk); #1;
      bus.reqtxen[1] = 1'b0;
      checkOutput("nonowner_busy2", {31'd0, bus.reqbusy[1]}, 32'd1);
      applyStimulus(0, 8'h58);
      applyStimulus(0, 8'h0A);
      bus.req[0] = 1'b0;
      waitGnt("cont_second", 2'b10, 1'b1, 100, n);
      applyStimulus(1, 8'h59);
      applyStimulus(1, 8'h0A);
      bus.req[1] = 1'b0;
      waitGnt("cont_done", 2'b00, 1'b1, 100, n);
      repeat (3) @(posedge clk);
      #1;

      // Idle timeout revokes the grant exactly 1024 cycles after it appears
      $display("[TB] timeout");
      bus.req = 2'b01;
      waitGnt("tmo_grant", 2'b00, 1'b0, 10, n);
      checkOutput("tmo_owner", {30'd0, bus.gnt}, 32'd1);
      bus.req[1] = 1'b1;
      waitGnt("tmo_drop", 2'b00, 1'b1, 2000, n);
      checkOutput("tmo_cycles", n, 32'd1024);
      waitGnt("tmo_next", 2'b00, 1'b0, 10, n);
      checkOutput("tmo_next_gnt", {30'd0, bus.gnt}, 32'd2);
      bus.req = 2'b00;
      waitGnt("tmo_done", 2'b00, 1'b1, 10, n);
      repeat (3) @(posedge clk);
      #1;

      // Owner drops req mid-packet after one byte
      $display("[TB] request drop");
      bus.req = 2'b01;
      waitGnt("drop_grant", 2'b00, 1'b0, 10, n);
      checkOutput("drop_owner", {30'd0, bus.gnt}, 32'd1);
      bus.req[1] = 1'b1;
      applyStimulus(0, 8'h31);
      bus.req[0] = 1'b0;
      waitGnt("drop_release", 2'b00, 1'b1, 100, n);
      waitGnt("drop_next", 2'b00, 1'b0, 10, n);
      checkOutput("drop_next_gnt", {30'd0, bus.gnt}, 32'd2);
      bus.req = 2'b00;
      waitGnt("drop_done", 2'b00, 1'b1, 10, n);
      repeat (3) @(posedge clk);
      #1;

      // Async reset while HOLD waits on a busy UART
      $display("[TB] reset in hold");
      bus.req = 2'b01;
      waitGnt("hold_grant", 2'b00, 1'b0, 10, n);
      checkOutput("hold_owner", {30'd0, bus.gnt}, 32'd1);
      applyStimulus(0, 8'h77);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("hold_uartbusy", {31'd0, bus.uartbusy}, 32'd1);
      bus.req = 2'b00;
      n_rst = 1'b0;
      #1;
      checkOutput("hold_rst_gnt", {30'd0, bus.gnt}, 32'd0);
      checkOutput("hold_rst_txen", {31'd0, bus.uarttxen}, 32'd0);
      checkOutput("hold_rst_busy", {30'd0, bus.reqbusy}, 32'd3);
      checkOutput("hold_rst_data", {24'd0, bus.uartdata}, 32'd0);
      @(posedge clk); #1;
      n_rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("post_rst_gnt", {30'd0, bus.gnt}, 32'd0);
      checkOutput("sb_empty", expQ.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
